// File: rtl/kdf_pkg.sv
// kdf_pkg: FSM state type, seed packing and width-check helpers for kdf_spongent_multi.
package kdf_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_KICK, S_WAIT, S_STORE, S_DONE
    } kdf_state_t;

    // Widest field the packing helper accepts, and the width of its scratch result.
    localparam int KDF_FIELD_W = 128;
    localparam int KDF_SEED_W  = 4 * KDF_FIELD_W;

    function automatic int kdf_seed_bits(input int pw, input int sw, input int cw, input int iw);
        return pw + sw + cw + iw;
    endfunction

    function automatic logic kdf_widths_ok(input int n, input int pw, input int sw,
                                           input int cw, input int iw);
        return (kdf_seed_bits(pw, sw, cw, iw) <= n) &&
               (pw <= KDF_FIELD_W) && (sw <= KDF_FIELD_W) &&
               (cw <= KDF_FIELD_W) && (iw <= KDF_FIELD_W);
    endfunction

    // {zero pad, psw, salt, cnt, idx}; callers zero-extend each field and truncate to N.
    function automatic logic [KDF_SEED_W-1:0] kdf_seed_pack(
        input logic [KDF_FIELD_W-1:0] psw,
        input logic [KDF_FIELD_W-1:0] salt,
        input logic [KDF_FIELD_W-1:0] cnt,
        input logic [KDF_FIELD_W-1:0] idx,
        input int sw, input int cw, input int iw
    );
        logic [KDF_SEED_W-1:0] s;
        s = KDF_SEED_W'(psw) << (sw + cw + iw);
        s = s | (KDF_SEED_W'(salt) << (cw + iw));
        s = s | (KDF_SEED_W'(cnt) << iw);
        s = s | KDF_SEED_W'(idx);
        return s;
    endfunction

endpackage

// File: rtl/kdf_block_ctrl.sv
// kdf_block_ctrl: iteration counter, block index and terminal compares for the KDF sequencer.
module kdf_block_ctrl #(
    parameter int COUNT_WIDTH = 24,
    parameter int IDX_WIDTH   = 8,
    parameter int KEY_BLOCKS  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   step,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic [IDX_WIDTH-1:0]   block_idx,
    output logic                   last_iter,
    output logic                   last_block
);
    logic [COUNT_WIDTH-1:0] iter_cnt, count_m1;

    // Comparing against count-1 before incrementing keeps the counter from ever wrapping.
    assign count_m1   = (count == '0) ? '0 : count - COUNT_WIDTH'(1);
    assign last_iter  = (iter_cnt >= count_m1);
    assign last_block = (block_idx == IDX_WIDTH'(KEY_BLOCKS - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            iter_cnt  <= '0;
            block_idx <= '0;
        end else if (step) begin
            if (!last_iter) begin
                iter_cnt <= iter_cnt + COUNT_WIDTH'(1);
            end else if (!last_block) begin
                iter_cnt  <= '0;
                block_idx <= block_idx + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/spongent.sv
// spongent: iterative Spongent sponge hash over one fixed-length N-bit message, one round per clock.
// rst is synchronous active-low; end_hash and hash hold until the next reset.
module spongent #(
    parameter int N = 128,
    parameter int c = 128,
    parameter int r = 8,
    parameter int R = 70,
    parameter logic [6:0] lCounter_initial_state  = 7'h7A,
    parameter logic [7:0] lCounter_feedback_coeff = 8'hC1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] message,
    output logic [N-1:0] hash,
    output logic         end_hash
);
    localparam int B  = c + r;
    localparam int NB = N / r;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam logic [15:0][3:0] SBOX = {4'h6, 4'h3, 4'hC, 4'h9, 4'h5, 4'h8, 4'hA, 4'h7,
                                         4'hF, 4'h4, 4'h1, 4'h2, 4'h0, 4'hB, 4'hD, 4'hE};

    typedef enum logic [1:0] {P_ABSORB, P_SQUEEZE, P_FIN} phase_t;

    phase_t               phase;
    logic [B-1:0]         st, st_in, st_rnd;
    logic [6:0]           lc, lc_next;
    logic [RW-1:0]        rnd;
    logic [BW-1:0]        blk;
    logic [NB-1:0][r-1:0] msg_arr;
    logic                 last_rnd, last_blk, capture;

    function automatic int perm_pos(input int j);
        return (j == B - 1) ? B - 1 : (j * (B / 4)) % (B - 1);
    endfunction

    function automatic logic [B-1:0] round_f(input logic [B-1:0] s, input logic [6:0] l);
        logic [B-1:0] t, p;
        t = s;
        for (int k = 0; k < 7; k++) begin
            t[k]         = t[k] ^ l[k];
            t[B - 1 - k] = t[B - 1 - k] ^ l[k];
        end
        for (int n = 0; n < B / 4; n++)
            t[4*n +: 4] = SBOX[t[4*n +: 4]];
        p = '0;
        for (int j = 0; j < B; j++)
            p[perm_pos(j)] = t[j];
        return p;
    endfunction

    assign msg_arr  = message;
    assign last_rnd = (rnd == RW'(R - 1));
    assign last_blk = (blk == BW'(NB - 1));
    assign capture  = (phase == P_SQUEEZE) && (rnd == '0);
    assign lc_next  = {lc[5:0], ^(lc & lCounter_feedback_coeff[7:1])};
    // Message blocks are absorbed MSB-first, XORed in on the first round of each permutation.
    assign st_in    = (phase == P_ABSORB && rnd == '0) ? (st ^ B'(msg_arr[BW'(NB - 1) - blk])) : st;
    assign st_rnd   = round_f(st_in, lc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase    <= P_ABSORB;
            st       <= '0;
            lc       <= lCounter_initial_state;
            rnd      <= '0;
            blk      <= '0;
            hash     <= '0;
            end_hash <= 1'b0;
        end else if (phase != P_FIN) begin
            if (capture)
                hash <= {hash[N-r-1:0], st[r-1:0]};
            if (capture && last_blk) begin
                phase    <= P_FIN;
                end_hash <= 1'b1;
            end else begin
                st <= st_rnd;
                if (last_rnd) begin
                    rnd <= '0;
                    lc  <= lCounter_initial_state;
                    if (last_blk) begin
                        blk   <= '0;
                        phase <= P_SQUEEZE;
                    end else begin
                        blk <= blk + BW'(1);
                    end
                end else begin
                    rnd <= rnd + RW'(1);
                    lc  <= lc_next;
                end
            end
        end
    end

endmodule

// File: rtl/kdf_spongent_multi.sv
// kdf_spongent_multi: start/done key-derivation engine producing KEY_BLOCKS iterated spongent digests.
// Define KDF_XOR_ACCUM_EN to make each block the XOR of all its digests instead of the last one.
module kdf_spongent_multi
    import kdf_pkg::*;
#(
    parameter int          N                       = 128,
    parameter int          c                       = 128,
    parameter int          r                       = 8,
    parameter int          R                       = 70,
    parameter logic [6:0]  lCounter_initial_state  = 7'h7A,
    parameter logic [7:0]  lCounter_feedback_coeff = 8'hC1,
    parameter int          SALT_WIDTH              = 64,
    parameter int          COUNT_WIDTH             = 24,
    parameter int          PSW_WIDTH               = 32,
    parameter int          IDX_WIDTH               = 8,
    parameter int          KEY_BLOCKS              = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SALT_WIDTH-1:0]   salt,
    input  logic [COUNT_WIDTH-1:0]  count,
    input  logic [PSW_WIDTH-1:0]    user_password,
    output logic                    busy,
    output logic                    done,
    output logic [KEY_BLOCKS*N-1:0] key_derivated
);
    if (!kdf_widths_ok(N, PSW_WIDTH, SALT_WIDTH, COUNT_WIDTH, IDX_WIDTH) ||
        KEY_BLOCKS < 1 || KEY_BLOCKS > (1 << IDX_WIDTH)) begin : g_cfg_err
        $error("kdf_spongent_multi: seed fields exceed N or KEY_BLOCKS out of range");
    end

    kdf_state_t                  state_q, state_d;
    logic [PSW_WIDTH-1:0]        psw_q;
    logic [SALT_WIDTH-1:0]       salt_q;
    logic [COUNT_WIDTH-1:0]      cnt_q;
    logic [N-1:0]                msg_q, hash, blk_res;
    logic [KEY_BLOCKS-1:0][N-1:0] key_q;
    logic [IDX_WIDTH-1:0]        block_idx;
    logic                        last_iter, last_block, end_hash, core_rst, accept;

    assign accept        = (state_q == S_IDLE) && start;
    assign core_rst      = rst && (state_q != S_KICK);
    assign key_derivated = key_q;

    spongent #(
        .N(N), .c(c), .r(r), .R(R),
        .lCounter_initial_state(lCounter_initial_state),
        .lCounter_feedback_coeff(lCounter_feedback_coeff)
    ) u_core (
        .clk(clk), .rst(core_rst), .message(msg_q), .hash(hash), .end_hash(end_hash)
    );

    kdf_block_ctrl #(
        .COUNT_WIDTH(COUNT_WIDTH), .IDX_WIDTH(IDX_WIDTH), .KEY_BLOCKS(KEY_BLOCKS)
    ) u_ctrl (
        .clk(clk), .rst(rst), .clr(accept), .step(state_q == S_STORE), .count(cnt_q),
        .block_idx(block_idx), .last_iter(last_iter), .last_block(last_block)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SEED;
            S_SEED:  begin busy = 1'b1; state_d = S_KICK; end
            S_KICK:  begin busy = 1'b1; state_d = S_WAIT; end
            S_WAIT:  begin busy = 1'b1; if (end_hash) state_d = S_STORE; end
            S_STORE: begin
                busy = 1'b1;
                if (!last_iter)     state_d = S_KICK;
                else if (last_block) state_d = S_DONE;
                else                state_d = S_SEED;
            end
            S_DONE:  begin done = 1'b1; state_d = S_IDLE; end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            psw_q  <= '0;
            salt_q <= '0;
            cnt_q  <= '0;
            msg_q  <= '0;
            key_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    psw_q  <= user_password;
                    salt_q <= salt;
                    cnt_q  <= count;
                    key_q  <= '0;
                end
                S_SEED: msg_q <= N'(kdf_seed_pack(KDF_FIELD_W'(psw_q), KDF_FIELD_W'(salt_q),
                                                  KDF_FIELD_W'(cnt_q), KDF_FIELD_W'(block_idx),
                                                  SALT_WIDTH, COUNT_WIDTH, IDX_WIDTH));
                // The digest becomes the next iteration's message.
                S_WAIT: if (end_hash) msg_q <= hash;
                S_STORE: if (last_iter) begin
                    for (int k = 0; k < KEY_BLOCKS; k++)
                        if (block_idx == IDX_WIDTH'(k)) key_q[k] <= blk_res;
                end
                default: ;
            endcase
        end
    end

`ifdef KDF_XOR_ACCUM_EN
    logic [N-1:0] acc_q;

    // Cleared at SEED so the first digest of each block loads straight in.
    always_ff @(posedge clk) begin
        if (!rst)                                acc_q <= '0;
        else if (state_q == S_SEED)              acc_q <= '0;
        else if (state_q == S_WAIT && end_hash)  acc_q <= acc_q ^ hash;
    end

    assign blk_res = acc_q;
`else
    assign blk_res = msg_q;
`endif

endmodule

// File: doc/kdf_spongent_multi.md
# kdf_spongent_multi

Parametrised, handshaked key-derivation engine built around the existing `spongent` hash core. It iterates the hash `count` times per output block and derives `KEY_BLOCKS` independent N-bit blocks, giving keys wider than one digest. It sits between the password/salt front end and key consumers such as cipher key schedules. It replaces free-running iteration with an explicit start/done handshake.

## Interface
- `N`, 128: digest width; width of one key block.
- `c`, 128 / `r`, 8 / `R`, 70: spongent capacity, rate, rounds; passed through to the core.
- `lCounter_initial_state`, 7'h7A / `lCounter_feedback_coeff`, 8'hC1: spongent LFSR settings; passed through to the core.
- `SALT_WIDTH`, 64 / `COUNT_WIDTH`, 24 / `PSW_WIDTH`, 32: input field widths.
- `IDX_WIDTH`, 8: block-index field width.
- `KEY_BLOCKS`, 2: number of output blocks. Range 1..2^IDX_WIDTH.
- Elaboration constraint: PSW_WIDTH+SALT_WIDTH+COUNT_WIDTH+IDX_WIDTH <= N.

Ports:
- `clk`  in  1  single clock. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request a derivation. Sampled only in IDLE.
- `salt`  in  SALT_WIDTH  salt. Latched on start acceptance.
- `count`  in  COUNT_WIDTH  iterations per block. Latched on start acceptance.
- `user_password`  in  PSW_WIDTH  password. Latched on start acceptance.
- `busy`  out  1  high from the cycle after acceptance until done.
- `done`  out  1  single-cycle pulse when the key is complete.
- `key_derivated`  out  KEY_BLOCKS*N  derived key. Block 0 occupies the LSBs.

## Operation
- States: IDLE, SEED, KICK, WAIT, STORE, DONE.
- IDLE: `start`=1 latches the inputs, clears the block index and iteration counter, clears `key_derivated`, and moves to SEED.
- SEED: loads the hash message register with `{zero pad, user_password, salt, count, block_idx}`. Goes to KICK.
- KICK: asserts the core reset for exactly one cycle. Goes to WAIT.
- WAIT: holds until the core's `end_hash`, then captures the digest into the message register and goes to STORE.
- STORE: increments the iteration counter.
  - If the counter is below the effective count, go to KICK. The next hash input is the previous digest.
  - Otherwise, write the block result into slot `block_idx` of `key_derivated`.
    - If this was the last block, go to DONE.
    - Otherwise, increment `block_idx`, clear the counter, and go to SEED.
- DONE: `done`=1 for one cycle, then go to IDLE. `key_derivated` holds until the next accepted start.
- Effective count is max(count, 1). `count`=0 performs exactly one hash per block.
- The iteration counter is COUNT_WIDTH bits wide and never wraps: the terminal compare occurs first.
- `start` while busy is ignored. Input changes after acceptance have no effect.
- Reset low at any cycle: FSM to IDLE, all registers cleared, core held in reset. The in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `key_derivated`=0.
- Acceptance in cycle t: `busy`=1 from t+1.
- Let L be the core hash latency, measured from the core-reset cycle to `end_hash`. Per iteration: L + 2 cycles (KICK, WAIT…end_hash, STORE).
- Per block: 1 (SEED) + effcount·(L+2).
- Total latency from acceptance to `done`: 1 + KEY_BLOCKS·(1 + effcount·(L+2)) cycles.
- `busy` falls in the same cycle `done` rises.
- A new `start` is accepted no earlier than the cycle after `done`.

## Configuration
- `KDF_XOR_ACCUM_EN` defined: each block result is the XOR of all effcount digests for that block (PBKDF2-style accumulator, one extra N-bit register). Latency is unchanged.
- `KDF_XOR_ACCUM_EN` undefined: the block result is the final digest only. No accumulator is built.

## Structure
- Package `kdf_pkg` holds:
  - the FSM state enum `kdf_state_t`;
  - a seed-packing function that zero-pads to N;
  - localparam helpers for the width check.
- Hash: one instance of the existing `spongent` core.
- One new sub-module, `kdf_block_ctrl`. It owns the iteration counter, block index, and terminal compares, and emits `last_iter`/`last_block` to the top-level FSM.

## Test plan
- Password 32'hDEADBEEF, salt 64'h0123456789ABCDEF, count=1, KEY_BLOCKS=2 -> `done` after the computed latency. Each block equals the golden model's H(seed with idx 0) and H(seed with idx 1).
- Same inputs, count=3 -> each block equals the golden model's H³(seed) (H³(seed) means the hash applied three times). With `KDF_XOR_ACCUM_EN`, each block equals H¹⊕H²⊕H³ of the seed.
- count=0 -> result identical to the count=1 case. `busy` lasts exactly the count=1 latency.
- `start` pulsed again mid-run with a different salt -> ignored. Result matches the first request. Exactly one `done` pulse.
- Reset driven low during WAIT of block 1 -> next cycle: `busy`=0, `done`=0, `key_derivated`=0. A fresh run afterwards produces the correct key.
- Back-to-back starts (second start in the cycle after `done`) -> second key is correct. The first key holds until the second acceptance.
